// File: rtl/reg_file_pkg.sv
// Shared datapath constants for the RV32I register file.
package reg_file_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NREGS    = 32;
    localparam int unsigned AW       = 5;
    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/n_bit_register.sv
// N-bit register with asynchronous active-high clear, enable and load.
module n_bit_register #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en && load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32-entry RV32I register file: two operand read ports, one debug read port,
// one synchronous write port; x0 is a constant zero.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned XLEN   = reg_file_pkg::XLEN,
    parameter int unsigned NREGS  = reg_file_pkg::NREGS,
    parameter int unsigned AW     = reg_file_pkg::AW,
    parameter int unsigned BYPASS = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_hit;

    assign regs[ZERO_REG] = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_entry
        logic load;
        assign load = we && (waddr == AW'(i));

        n_bit_register #(
            .N(XLEN)
        ) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (1'b1),
            .load(load),
            .d   (wdata),
            .q   (regs[i])
        );
    end

    // A write that can actually land this edge; reset discards it, so bypass must too.
    assign wr_hit = we && (waddr != AW'(ZERO_REG)) && !rst;

    always_comb begin
        rdata1   = regs[raddr1];
        rdata2   = regs[raddr2];
        dbg_data = regs[dbg_addr];
        if (BYPASS != 0 && wr_hit) begin
            if (raddr1 == waddr) begin
                rdata1 = wdata;
            end
            if (raddr2 == waddr) begin
                rdata2 = wdata;
            end
            if (dbg_addr == waddr) begin
                dbg_data = wdata;
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; one instance without and one with bypass.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  raddr1, raddr2, waddr, dbg_addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata2, dbg_data;
    logic [31:0] b_rdata1, b_rdata2, b_dbg_data;

    int checks = 0;
    int errors = 0;

    reg_file #(.BYPASS(0)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .raddr1  (raddr1),
        .raddr2  (raddr2),
        .rdata1  (rdata1),
        .rdata2  (rdata2),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    reg_file #(.BYPASS(1)) u_byp (
        .clk     (clk),
        .rst     (rst),
        .raddr1  (raddr1),
        .raddr2  (raddr2),
        .rdata1  (b_rdata1),
        .rdata2  (b_rdata2),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .dbg_addr(dbg_addr),
        .dbg_data(b_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = 5'd5; raddr2 = 5'd31; dbg_addr = 5'd17;
        #2;
        checks++;
        if (rdata1 !== 32'h0) begin
            $display("FAIL reset_rdata1 got %h want %h", rdata1, 32'h0); errors++;
        end
        checks++;
        if (rdata2 !== 32'h0) begin
            $display("FAIL reset_rdata2 got %h want %h", rdata2, 32'h0); errors++;
        end
        checks++;
        if (dbg_data !== 32'h0) begin
            $display("FAIL reset_dbg got %h want %h", dbg_data, 32'h0); errors++;
        end
        step(); step();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            $display("FAIL post_reset_rdata1 got %h want %h", rdata1, 32'h0); errors++;
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        raddr1 = 5'd5; dbg_addr = 5'd5;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            $display("FAIL wr_old_rdata1 got %h want %h", rdata1, 32'h0); errors++;
        end
        checks++;
        if (dbg_data !== 32'h0) begin
            $display("FAIL wr_old_dbg got %h want %h", dbg_data, 32'h0); errors++;
        end
        step();
        we = 1'b0;
        checks++;
        if (rdata1 !== 32'hDEAD_BEEF) begin
            $display("FAIL wr_new_rdata1 got %h want %h", rdata1, 32'hDEAD_BEEF); errors++;
        end
        checks++;
        if (dbg_data !== 32'hDEAD_BEEF) begin
            $display("FAIL wr_new_dbg got %h want %h", dbg_data, 32'hDEAD_BEEF); errors++;
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        checks++;
        if (b_rdata1 !== 32'h0) begin
            $display("FAIL x0_bypass got %h want %h", b_rdata1, 32'h0); errors++;
        end
        step();
        we = 1'b0;
        checks++;
        if (rdata1 !== 32'h0) begin
            $display("FAIL x0_rdata1 got %h want %h", rdata1, 32'h0); errors++;
        end
        checks++;
        if (rdata2 !== 32'h0) begin
            $display("FAIL x0_rdata2 got %h want %h", rdata2, 32'h0); errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        @(negedge clk);
        we = 1'b1; waddr = 5'd3; wdata = 32'h11;
        step();
        waddr = 5'd4; wdata = 32'h22;
        step();
        we = 1'b0;
        raddr1 = 5'd3; raddr2 = 5'd4;
        #1;
        checks++;
        if (rdata1 !== 32'h11) begin
            $display("FAIL b2b_rdata1 got %h want %h", rdata1, 32'h11); errors++;
        end
        checks++;
        if (rdata2 !== 32'h22) begin
            $display("FAIL b2b_rdata2 got %h want %h", rdata2, 32'h22); errors++;
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            case (i)
                3:       exp = 32'h11;
                4:       exp = 32'h22;
                5:       exp = 32'hDEAD_BEEF;
                default: exp = 32'h0;
            endcase
            checks++;
            if (dbg_data !== exp) begin
                $display("FAIL b2b_entry%0d got %h want %h", i, dbg_data, exp); errors++;
            end
        end
        raddr1 = 5'd3; raddr2 = 5'd3;
        #1;
        checks++;
        if (rdata1 !== 32'h11 || rdata2 !== 32'h11) begin
            $display("FAIL same_addr got %h/%h want %h", rdata1, rdata2, 32'h11); errors++;
        end
    endtask

    task automatic test_no_write();
        @(negedge clk);
        we = 1'b0; waddr = 5'd9; wdata = 32'hABCD;
        raddr1 = 5'd9;
        step();
        checks++;
        if (rdata1 !== 32'h0) begin
            $display("FAIL no_write_x9 got %h want %h", rdata1, 32'h0); errors++;
        end
    endtask

    task automatic test_bypass();
        write_reg(5'd6, 32'h1);
        @(negedge clk);
        we = 1'b1; waddr = 5'd6; wdata = 32'h77;
        raddr2 = 5'd6; dbg_addr = 5'd6; raddr1 = 5'd3;
        #1;
        checks++;
        if (rdata2 !== 32'h1) begin
            $display("FAIL nobyp_rdata2 got %h want %h", rdata2, 32'h1); errors++;
        end
        checks++;
        if (b_rdata2 !== 32'h77) begin
            $display("FAIL byp_rdata2 got %h want %h", b_rdata2, 32'h77); errors++;
        end
        checks++;
        if (b_dbg_data !== 32'h77) begin
            $display("FAIL byp_dbg got %h want %h", b_dbg_data, 32'h77); errors++;
        end
        checks++;
        if (b_rdata1 !== 32'h11) begin
            $display("FAIL byp_other_port got %h want %h", b_rdata1, 32'h11); errors++;
        end
        step();
        we = 1'b0;
        checks++;
        if (rdata2 !== 32'h77) begin
            $display("FAIL nobyp_after_edge got %h want %h", rdata2, 32'h77); errors++;
        end
    endtask

    task automatic test_mid_reset();
        write_reg(5'd7, 32'h1234_5678);
        raddr1 = 5'd7; raddr2 = 5'd8; dbg_addr = 5'd7;
        #1;
        checks++;
        if (rdata1 !== 32'h1234_5678) begin
            $display("FAIL pre_rst_x7 got %h want %h", rdata1, 32'h1234_5678); errors++;
        end
        @(negedge clk);
        we = 1'b1; waddr = 5'd8; wdata = 32'h55;
        rst = 1'b1;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            $display("FAIL rst_async_x7 got %h want %h", rdata1, 32'h0); errors++;
        end
        checks++;
        if (b_rdata2 !== 32'h0) begin
            $display("FAIL rst_byp_x8 got %h want %h", b_rdata2, 32'h0); errors++;
        end
        step(); step();
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        #1;
        checks++;
        if (rdata2 !== 32'h0) begin
            $display("FAIL rst_discard_x8 got %h want %h", rdata2, 32'h0); errors++;
        end
        raddr1 = 5'd3;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            $display("FAIL rst_clear_x3 got %h want %h", rdata1, 32'h0); errors++;
        end
        write_reg(5'd2, 32'h99);
        raddr1 = 5'd2;
        #1;
        checks++;
        if (rdata1 !== 32'h99) begin
            $display("FAIL first_write_after_rst got %h want %h", rdata1, 32'h99); errors++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_back_to_back();
        test_no_write();
        test_bypass();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
